// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state codes and port indices.
package dmem_arbiter_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } darb_state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    // Read-latency countdown is 3 bits wide, enough for latencies 1..7.
    localparam int CNT_W = 3;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on contention the port not granted last wins.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       valid
);

    always_comb begin
        valid   = |req;
        gnt_idx = PORT_CORE;
        case (req)
            2'b01:   gnt_idx = PORT_CORE;
            2'b10:   gnt_idx = PORT_DBG;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = PORT_CORE;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core (port 0) and the debug loader (port 1),
// one access in flight, with round-robin arbitration and fixed read-latency tracking.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int N          = 32,
    parameter int ACC_W      = 3,
    parameter int RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [N-1:0]     addr0,
    input  logic [N-1:0]     addr1,
    input  logic [N-1:0]     wdata0,
    input  logic [N-1:0]     wdata1,
    input  logic [ACC_W-1:0] acc0,
    input  logic [ACC_W-1:0] acc1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [N-1:0]     rdata0,
    output logic [N-1:0]     rdata1,
    output logic             mem_rd_ena,
    output logic             mem_wr_ena,
    output logic [N-1:0]     mem_addr,
    output logic [N-1:0]     mem_wr_data,
    output logic [ACC_W-1:0] mem_access,
    input  logic [N-1:0]     mem_rd_data
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY - 1);

    darb_state_t       r_state;
    darb_state_t       w_next_state;

    logic              w_arb_idx;
    logic              w_arb_valid;

    logic              r_owner;
    logic              r_last;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done0;
    logic              r_done1;
    logic [N-1:0]      r_rdata0;
    logic [N-1:0]      r_rdata1;
    logic [N-1:0]      r_addr;
    logic [N-1:0]      r_wdata;
    logic [ACC_W-1:0]  r_acc;

    logic              w_take;

    rr_arb2 u_rr_arb2 (
        .req     ({req1, req0}),
        .last    (r_last),
        .gnt_idx (w_arb_idx),
        .valid   (w_arb_valid)
    );

    assign w_take = (r_state == ST_IDLE) && w_arb_valid;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_arb_valid) w_next_state = ST_ACCESS;
            ST_ACCESS: w_next_state = r_we ? ST_IDLE : ST_WAIT;
            ST_WAIT:   if (r_cnt == '0) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Control registers: ownership, fairness, latency countdown, done pulses and returned data.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_owner  <= PORT_CORE;
            r_last   <= PORT_DBG;
            r_we     <= 1'b0;
            r_cnt    <= '0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_owner <= w_arb_idx;
                        r_last  <= w_arb_idx;
                        r_we    <= w_arb_idx ? we1 : we0;
                    end
                end
                ST_ACCESS: begin
                    if (r_we) begin
                        r_done0 <= (r_owner == PORT_CORE);
                        r_done1 <= (r_owner == PORT_DBG);
                    end else begin
                        r_cnt <= CNT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_owner == PORT_CORE) begin
                        r_done0  <= 1'b1;
                        r_rdata0 <= mem_rd_data;
                    end else begin
                        r_done1  <= 1'b1;
                        r_rdata1 <= mem_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Latched command fields; only ever observed after a grant has loaded them.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_addr  <= w_arb_idx ? addr1  : addr0;
            r_wdata <= w_arb_idx ? wdata1 : wdata0;
            r_acc   <= w_arb_idx ? acc1   : acc0;
        end
    end

    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        mem_rd_ena  = 1'b0;
        mem_wr_ena  = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_access  = '0;
        case (r_state)
            ST_ACCESS: begin
                gnt0        = (r_owner == PORT_CORE);
                gnt1        = (r_owner == PORT_DBG);
                mem_wr_ena  = r_we;
                mem_rd_ena  = ~r_we;
                mem_addr    = r_addr;
                mem_wr_data = r_wdata;
                mem_access  = r_acc;
            end
            ST_WAIT: begin
                mem_addr    = r_addr;
                mem_wr_data = r_wdata;
                mem_access  = r_acc;
            end
            default: ;
        endcase
    end

    assign done0  = r_done0;
    assign done1  = r_done1;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read-latency-3 memory model behind it.
module tb_dmem_arbiter;

    localparam int N   = 32;
    localparam int AW  = 3;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rstb;
    logic          req0, req1, we0, we1;
    logic [N-1:0]  addr0, addr1, wdata0, wdata1;
    logic [AW-1:0] acc0, acc1;
    logic          gnt0, gnt1, done0, done1;
    logic [N-1:0]  rdata0, rdata1;
    logic          mem_rd_ena, mem_wr_ena;
    logic [N-1:0]  mem_addr, mem_wr_data, mem_rd_data;
    logic [AW-1:0] mem_access;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.N(N), .ACC_W(AW), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rstb(rstb),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .acc0(acc0), .acc1(acc1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_rd_ena(mem_rd_ena), .mem_wr_ena(mem_wr_ena),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_access(mem_access),
        .mem_rd_data(mem_rd_data)
    );

    // Memory model: read data is presented only in the cycle LAT edges after the strobe edge.
    logic [N-1:0]   mem    [0:63];
    logic [N-1:0]   pipe_d [0:LAT-1];
    logic [LAT-1:0] pipe_v;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pipe_v <= '0;
        end else begin
            if (mem_wr_ena) mem[mem_addr[7:2]] <= mem_wr_data;
            pipe_v[0] <= mem_rd_ena;
            pipe_d[0] <= mem_rd_ena ? mem[mem_addr[7:2]] : '0;
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign mem_rd_data = pipe_v[LAT-1] ? pipe_d[LAT-1] : '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; acc0 = '0; acc1 = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_strobe", {mem_rd_ena, mem_wr_ena}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        rstb = 1'b1;
        cyc();

        // Port 0 write then read of 0x10
        we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF; acc0 = 3'b010; req0 = 1;
        cyc();
        chk("t1_gnt0", gnt0, 1);
        chk("t1_gnt1", gnt1, 0);
        chk("t1_wr", mem_wr_ena, 1);
        chk("t1_rd", mem_rd_ena, 0);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_wdata", mem_wr_data, 32'hDEADBEEF);
        chk("t1_acc", mem_access, 3'b010);
        chk("t1_done_early", done0, 0);
        req0 = 0;
        cyc();
        chk("t1_wdone", done0, 1);
        chk("t1_wdone_gnt", gnt0, 0);
        chk("t1_idle_wr", mem_wr_ena, 0);
        chk("t1_idle_addr", mem_addr, 0);
        we0 = 0; req0 = 1;
        cyc();
        chk("t1_rgnt", gnt0, 1);
        chk("t1_rstrobe", mem_rd_ena, 1);
        chk("t1_rwr", mem_wr_ena, 0);
        chk("t1_done_after", done0, 0);
        req0 = 0;
        for (int i = 1; i <= LAT; i++) begin
            cyc();
            chk("t1_wait_done", done0, 0);
            chk("t1_wait_rd", mem_rd_ena, 0);
            chk("t1_wait_addr", mem_addr, 32'h10);
        end
        cyc();
        chk("t1_rdone", done0, 1);
        chk("t1_rdata", rdata0, 32'hDEADBEEF);
        cyc();
        chk("t1_done_pulse", done0, 0);
        chk("t1_rdata_hold", rdata0, 32'hDEADBEEF);

        // Port 1 write then latency-3 read of 0x20
        we1 = 1; addr1 = 32'h20; wdata1 = 32'h12345678; acc1 = 3'b000; req1 = 1;
        cyc();
        chk("t3_wgnt1", gnt1, 1);
        chk("t3_wgnt0", gnt0, 0);
        req1 = 0;
        cyc();
        chk("t3_wdone1", done1, 1);
        chk("t3_wdone0", done0, 0);
        we1 = 0; req1 = 1;
        cyc();
        chk("t3_rgnt1", gnt1, 1);
        chk("t3_rstrobe", mem_rd_ena, 1);
        req1 = 0;
        for (int i = 1; i <= LAT; i++) begin
            cyc();
            chk("t3_wait_done1", done1, 0);
            chk("t3_wait_rd", mem_rd_ena, 0);
        end
        cyc();
        chk("t3_rdone1", done1, 1);
        chk("t3_rdata1", rdata1, 32'h12345678);
        chk("t3_rdata0_keep", rdata0, 32'hDEADBEEF);
        chk("t3_done0", done0, 0);

        // Short req1 pulse while port 0 read is in flight
        we0 = 0; addr0 = 32'h10; req0 = 1;
        cyc();
        chk("t5_gnt0", gnt0, 1);
        req0 = 0;
        we1 = 1; addr1 = 32'h3C; wdata1 = 32'h0000_5A5A; req1 = 1;
        cyc();
        req1 = 0;
        chk("t5_no_gnt1", gnt1, 0);
        chk("t5_no_wr", mem_wr_ena, 0);
        for (int i = 2; i <= LAT; i++) begin
            cyc();
            chk("t5_wait_gnt1", gnt1, 0);
            chk("t5_wait_addr", mem_addr, 32'h10);
        end
        cyc();
        chk("t5_done0", done0, 1);
        chk("t5_rdata0", rdata0, 32'hDEADBEEF);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("t5_after_gnt1", gnt1, 0);
            chk("t5_after_mem", {mem_rd_ena, mem_wr_ena}, 0);
        end

        // Reset, then both ports requesting continuously: grants alternate 0,1,0,1
        rstb = 1'b0;
        cyc();
        rstb = 1'b1;
        cyc();
        chk("t2_rdata0_clr", rdata0, 0);
        we0 = 1; addr0 = 32'h30; wdata0 = 32'hAAAA0000;
        we1 = 1; addr1 = 32'h34; wdata1 = 32'h00005555;
        req0 = 1; req1 = 1;
        for (int g = 0; g < 4; g++) begin
            cyc();
            chk("t2_gnt0", gnt0, (g % 2 == 0) ? 1 : 0);
            chk("t2_gnt1", gnt1, (g % 2 == 1) ? 1 : 0);
            chk("t2_addr", mem_addr, (g % 2 == 0) ? 32'h30 : 32'h34);
            cyc();
            chk("t2_dgnt", {gnt1, gnt0}, 0);
            chk("t2_done", {done1, done0}, (g % 2 == 0) ? 2'b01 : 2'b10);
            if (g == 3) begin
                req0 = 0; req1 = 0;
            end
        end
        cyc();
        chk("t2_quiet", {gnt1, gnt0}, 0);

        // Back-to-back port 0 writes with req0 held
        we0 = 1; addr0 = 32'h40; wdata0 = 32'h1; req0 = 1;
        for (int j = 0; j < 3; j++) begin
            cyc();
            chk("t6_gnt0", gnt0, 1);
            chk("t6_addr", mem_addr, 32'h40 + 4 * j);
            chk("t6_wdata", mem_wr_data, 32'h1 + j);
            addr0 = 32'h44 + 4 * j; wdata0 = 32'h2 + j;
            if (j == 2) req0 = 0;
            cyc();
            chk("t6_done0", done0, 1);
            chk("t6_dgnt0", gnt0, 0);
        end
        cyc();
        chk("t6_end_gnt0", gnt0, 0);
        chk("t6_end_done0", done0, 0);

        // Reset during WAIT with both ports pending
        we0 = 0; addr0 = 32'h40; req0 = 1;
        cyc();
        chk("t4_gnt0", gnt0, 1);
        we1 = 1; addr1 = 32'h50; wdata1 = 32'h77; req1 = 1;
        cyc();
        chk("t4_in_wait", mem_addr, 32'h40);
        rstb = 1'b0;
        #1;
        chk("t4_rst_gnt", {gnt1, gnt0}, 0);
        chk("t4_rst_done", {done1, done0}, 0);
        chk("t4_rst_strobe", {mem_rd_ena, mem_wr_ena}, 0);
        chk("t4_rst_addr", mem_addr, 0);
        chk("t4_rst_wdata", mem_wr_data, 0);
        we0 = 1; wdata0 = 32'h99;
        cyc();
        chk("t4_rst_edge_done", {done1, done0}, 0);
        rstb = 1'b1;
        cyc();
        chk("t4_first_gnt0", gnt0, 1);
        chk("t4_first_gnt1", gnt1, 0);
        chk("t4_no_done", {done1, done0}, 0);
        req0 = 0;
        cyc();
        chk("t4_done0", done0, 1);
        cyc();
        chk("t4_then_gnt1", gnt1, 1);
        req1 = 0;
        cyc();
        chk("t4_done1", done1, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
